// File: rtl/mouse_quad_encoder.sv
// PS/2 mouse packet deltas -> per-axis quadrature {A,B} spinner emulation.
// Saturating signed accumulators are drained one quadrature state per divider tick.
module mouse_quad_encoder #(
    parameter int unsigned          CHANNELS    = 1,
    parameter int unsigned          ACC_W       = 12,
    parameter int unsigned          STEP_DIV    = 2048,
    parameter int unsigned          SCALE_SHIFT = 0,
    parameter logic [CHANNELS-1:0]  INVERT      = '0
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [24:0]             ps2_mouse,
    input  logic                    clear,
    output logic [2*CHANNELS-1:0]   quad,
    output logic [CHANNELS-1:0]     busy
);

    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_S = -MAX_S;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             tog_d;
    logic             armed;
    logic             packet;
    logic             unused_ps2;

    assign unused_ps2 = ^ps2_mouse;
    assign tick       = (div_cnt == DIV_W'(STEP_DIV - 1));
    assign packet     = armed & (ps2_mouse[24] ^ tog_d);

    // Shared step divider and packet toggle tracking; arming skips the first sample.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tog_d   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            tog_d   <= ps2_mouse[24];
            armed   <= 1'b1;
        end
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        logic [8:0]              delta;
        logic signed [ACC_W-1:0] d;
        logic signed [ACC_W-1:0] pos;
        logic signed [ACC_W-1:0] pos_next;
        logic signed [SUM_W-1:0] sum;
        logic signed [1:0]       s;
        logic                    step;
        logic [1:0]              q;
        logic [1:0]              q_next;
        logic                    busy_q;

        if (i == 0) begin : g_x
            assign delta = {ps2_mouse[4], ps2_mouse[15:8]};
        end else begin : g_y
            assign delta = {ps2_mouse[5], ps2_mouse[23:16]};
        end

        assign step = tick && (pos != '0);

        // Scaled/inverted delta, step direction and saturating accumulator update.
        always_comb begin
            d        = ACC_W'($signed(delta)) <<< SCALE_SHIFT;
            s        = 2'sd0;
            sum      = '0;
            pos_next = pos;
            q_next   = q;
            if (INVERT[i]) d = -d;
            if (step) s = pos[ACC_W-1] ? -2'sd1 : 2'sd1;
            sum = SUM_W'(pos) - SUM_W'(s) + (packet ? SUM_W'(d) : SUM_W'(0));
            if (sum > MAX_S)       pos_next = ACC_W'(MAX_S);
            else if (sum < MIN_S)  pos_next = ACC_W'(MIN_S);
            else                   pos_next = ACC_W'(sum);
            if (pos[ACC_W-1]) begin
                case (q)
                    2'b00:   q_next = 2'b01;
                    2'b01:   q_next = 2'b11;
                    2'b11:   q_next = 2'b10;
                    default: q_next = 2'b00;
                endcase
            end else begin
                case (q)
                    2'b00:   q_next = 2'b10;
                    2'b10:   q_next = 2'b11;
                    2'b11:   q_next = 2'b01;
                    default: q_next = 2'b00;
                endcase
            end
        end

        // Clear wins over packet and step but never disturbs the encoder phase.
        always_ff @(posedge clk_sys or negedge reset) begin
            if (!reset) begin
                pos    <= '0;
                q      <= 2'b11;
                busy_q <= 1'b0;
            end else if (clear) begin
                pos    <= '0;
                busy_q <= 1'b0;
            end else begin
                pos    <= pos_next;
                busy_q <= (pos_next != '0);
                if (step) q <= q_next;
            end
        end

        assign quad[2*i+1:2*i] = q;
        assign busy[i]         = busy_q;
    end

endmodule

// File: tb/tb_mouse_quad_encoder.sv
// Directed bench for mouse_quad_encoder: drain, inversion, two axes, simultaneous events,
// clear, saturation at both limits and asynchronous reset.
module tb_mouse_quad_encoder;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [24:0] ps2_a, ps2_b, ps2_c;
    logic        clear_a;
    logic        clear_0 = 1'b0;
    logic [3:0]  quad_a;
    logic [1:0]  busy_a;
    logic [1:0]  quad_b, quad_c;
    logic        busy_b, busy_c;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk_sys = ~clk_sys;

    mouse_quad_encoder #(.CHANNELS(2), .ACC_W(12), .STEP_DIV(4), .SCALE_SHIFT(0), .INVERT(2'b00))
        dut_a (.clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_a), .clear(clear_a),
               .quad(quad_a), .busy(busy_a));

    mouse_quad_encoder #(.CHANNELS(1), .ACC_W(12), .STEP_DIV(4), .SCALE_SHIFT(0), .INVERT(1'b1))
        dut_b (.clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_b), .clear(clear_0),
               .quad(quad_b), .busy(busy_b));

    mouse_quad_encoder #(.CHANNELS(1), .ACC_W(10), .STEP_DIV(4), .SCALE_SHIFT(0), .INVERT(1'b0))
        dut_c (.clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_c), .clear(clear_0),
               .quad(quad_c), .busy(busy_c));

    function automatic logic [24:0] mk(input logic t, input logic [8:0] x, input logic [8:0] y);
        return {t, y[7:0], x[7:0], 2'b00, y[8], x[8], 4'b0000};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick1();
    endtask

    task automatic drain_c(output int steps);
        logic [1:0] prev;
        steps = 0;
        prev  = quad_c;
        for (int k = 0; k < 3000 && busy_c; k++) begin
            tick1();
            if (quad_c != prev) steps++;
            prev = quad_c;
        end
        check("drain_c_timeout", 32'(busy_c), 32'd0);
    endtask

    int steps;

    initial begin
        reset   = 1'b0;
        clear_a = 1'b0;
        ps2_a   = mk(1'b1, 9'd0, 9'd0);
        ps2_b   = mk(1'b0, 9'd0, 9'd0);
        ps2_c   = mk(1'b0, 9'd0, 9'd0);
        #23;
        check("rst_quad_a", 32'(quad_a), 32'hF);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_quad_b", 32'(quad_b), 32'h3);
        check("rst_busy_c", 32'(busy_c), 32'h0);

        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        cyc   = 0;

        run_to(3);
        check("no_pkt_release_busy", 32'(busy_a), 32'h0);
        check("no_pkt_release_quad", 32'(quad_a), 32'hF);

        ps2_a = mk(1'b0, 9'd3, 9'h1FF);
        ps2_b = mk(1'b1, 9'd2, 9'd0);
        run_to(4);
        check("pkt_busy_a", 32'(busy_a), 32'h3);
        check("pkt_quad_a", 32'(quad_a), 32'hF);
        check("pkt_busy_b", 32'(busy_b), 32'h1);
        run_to(7);
        check("pre_tick_quad_a", 32'(quad_a), 32'hF);
        check("pre_tick_quad_b", 32'(quad_b), 32'h3);
        run_to(8);
        check("step1_quad_a", 32'(quad_a), 32'b1001);
        check("step1_busy_a", 32'(busy_a), 32'h1);
        check("inv_step1_quad_b", 32'(quad_b), 32'b10);
        check("inv_step1_busy_b", 32'(busy_b), 32'h1);
        run_to(11);
        check("hold_quad_a", 32'(quad_a), 32'b1001);
        run_to(12);
        check("step2_quad_a", 32'(quad_a), 32'b1000);
        check("inv_step2_quad_b", 32'(quad_b), 32'b00);
        check("inv_done_busy_b", 32'(busy_b), 32'h0);
        run_to(16);
        check("step3_quad_a", 32'(quad_a), 32'b1010);
        check("drained_busy_a", 32'(busy_a), 32'h0);
        run_to(20);
        check("idle_quad_a", 32'(quad_a), 32'b1010);
        check("inv_idle_quad_b", 32'(quad_b), 32'b00);

        // pos=+1, then a -1 packet lands on the tick edge
        run_to(21);
        ps2_a = mk(1'b1, 9'd1, 9'd0);
        run_to(22);
        check("sim_setup_busy", 32'(busy_a), 32'h1);
        run_to(23);
        ps2_a = mk(1'b0, 9'h1FF, 9'd0);
        run_to(24);
        check("sim_plus_step", 32'(quad_a), 32'b1011);
        check("sim_busy_neg", 32'(busy_a), 32'h1);
        run_to(28);
        check("sim_minus_step", 32'(quad_a), 32'b1010);
        check("sim_done_busy", 32'(busy_a), 32'h0);

        // Clear mid-drain, with a packet in the clear cycle that must be dropped
        run_to(29);
        ps2_a = mk(1'b1, 9'd3, 9'd0);
        run_to(32);
        check("clr_pre_quad", 32'(quad_a), 32'b1011);
        check("clr_pre_busy", 32'(busy_a), 32'h1);
        run_to(33);
        clear_a = 1'b1;
        ps2_a   = mk(1'b0, 9'd5, 9'd0);
        run_to(34);
        clear_a = 1'b0;
        check("clr_busy", 32'(busy_a), 32'h0);
        run_to(36);
        check("clr_frozen_quad", 32'(quad_a), 32'b1011);
        check("clr_pkt_dropped", 32'(busy_a), 32'h0);
        run_to(40);
        check("clr_frozen_quad2", 32'(quad_a), 32'b1011);

        // Positive saturation: 3 x +255 on non-tick edges clamps to +511
        ps2_c = mk(1'b1, 9'h0FF, 9'd0);
        tick1();
        ps2_c = mk(1'b0, 9'h0FF, 9'd0);
        tick1();
        ps2_c = mk(1'b1, 9'h0FF, 9'd0);
        tick1();
        check("sat_pos_busy", 32'(busy_c), 32'h1);
        drain_c(steps);
        check("sat_pos_steps", 32'(steps), 32'd511);
        check("sat_pos_phase", 32'(quad_c), 32'b10);

        // Negative saturation: 3 x -256 clamps to -511, never -512
        while (cyc % 4 != 0) tick1();
        ps2_c = mk(1'b0, 9'h100, 9'd0);
        tick1();
        ps2_c = mk(1'b1, 9'h100, 9'd0);
        tick1();
        ps2_c = mk(1'b0, 9'h100, 9'd0);
        tick1();
        check("sat_neg_busy", 32'(busy_c), 32'h1);
        drain_c(steps);
        check("sat_neg_steps", 32'(steps), 32'd511);
        check("sat_neg_phase", 32'(quad_c), 32'b11);

        // Asynchronous reset mid-drain
        ps2_a = mk(1'b1, 9'd2, 9'd0);
        tick1();
        check("ar_pre_busy", 32'(busy_a), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("ar_quad_a", 32'(quad_a), 32'hF);
        check("ar_busy_a", 32'(busy_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
